ipf_lcu_scheduler: RTL
======================

// Module: ipf_lcu_scheduler
// PURPOSE
//  Frame-level sequencer for the IPF filter. On start, walks every LCU of a 128x128 frame
//  in raster order, fetches per-LCU filter parameters from a param table, streams the LCU's
//  pixels from the image ROM into the filter, and counts filtered outputs to close each LCU.
//  Pulses done when the last LCU's last output has been observed.
// PARAMETERS
//  IMG_W   128  frame width/height in pixels (square frame)
//  AW      14   image address width (log2(IMG_W*IMG_W))
//  PW      24   param word width {type[23:22],band_pos[21:17],wo_class[16],offset[15:0]}
// PORTS
//  clk           in   1   single clock, all logic rising-edge
//  reset         in   1   asynchronous, active-high
//  start         in   1   1-cycle pulse; sampled only in IDLE
//  cfg_lcu_size  in   2   0:16, 1:32, 2:64; 3 illegal; latched at start
//  img_addr      out  AW  image ROM read address; data returns 1 cycle later
//  img_rd        out  1   image ROM read strobe
//  img_data      in   8   image ROM read data (valid cycle after img_rd)
//  prm_addr      out  6   param table index = {lcu_y,lcu_x}
//  prm_rd        out  1   param read strobe; data valid next cycle
//  prm_data      in   PW  param word
//  ipf_busy      in   1   filter busy; pixel consumed on edge with in_en=1 & ipf_busy=0
//  ipf_out_en    in   1   filter output strobe; one per filtered pixel
//  in_en, din    out  1,8 pixel valid / pixel to filter
//  ipf_type,ipf_band_pos,ipf_wo_class,ipf_offset  out 2,5,1,16  current LCU params
//  lcu_x, lcu_y, lcu_size  out 3,3,2  current LCU coordinates and latched size
//  done          out  1   1-cycle pulse at frame completion
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, FIFO empty, counters 0; reset mid-frame aborts, no done.
//  L = 16<<lcu_size; grid N = IMG_W/L (8/4/2); LCU count N*N (64/16/4); pixels per LCU L*L.
//  FSM: IDLE -start&size!=3-> PARAM (prm_rd=1, prm_addr={lcu_y,lcu_x}) -> PLAT (latch
//   prm_data into ipf_* regs) -> RUN -> (out_cnt==L*L) -> NEXT -> PARAM, or DONE if last
//   LCU -> IDLE. DONE asserts done for exactly one cycle. start with size==3: ignored.
//  ipf_* outputs change only in PLAT; held stable throughout RUN.
//  Pixel order in LCU: raster r=0..L-1, c=0..L-1; addr = (lcu_y*L+r)*IMG_W + lcu_x*L + c.
//  Fetch: 2-entry prefetch FIFO of pixels. In RUN, issue img_rd when
//   (fifo_count + inflight) < 2 and feed_cnt < L*L; feed_cnt counts issued reads.
//  Feed: in_en = fifo_not_empty & RUN; din = FIFO head. Pop on in_en & !ipf_busy.
//   Push (img_data) and pop in same cycle allowed; count unchanged. No overflow possible.
//  out_cnt (13b) increments on ipf_out_en in RUN; reaching L*L ends LCU. ipf_out_en outside
//   RUN is ignored. in_en never asserted after L*L pixels issued for the LCU.
//  Counters wrap-free: feed/out counters cleared in NEXT; lcu_x increments, at N-1 wraps to 0
//   and lcu_y increments. Last LCU: lcu_x==N-1 & lcu_y==N-1.
//  Latency: start -> first in_en = 4 cycles (PARAM, PLAT, img_rd, data).
// STRUCTURE
//  Package ipf_pkg: lcu_size encoding constants, param-word field offsets, L/N lookup function.
//  Sub-module ipf_pix_fifo (2-entry, 8-bit, push/pop/count) instantiated once; rest inline.
// TESTING
//  size=2, params all type 0, ipf model busy=0, out_en 1 cycle after consume -> 4 LCUs,
//   16384 pixels fed, addresses 0..63 then 128.., done once after 16384th out_en.
//  size=0, LCU(1,0): first img_addr=16, 17th pixel addr=128+16; prm_addr sequence 0,1..63.
//  ipf_busy held 1 for 5 cycles mid-RUN -> in_en/din stable, FIFO holds 2, no reads issued.
//  param table word 0x9A_F10C for LCU 3 -> ipf_type=2, band_pos=13, wo_class=0,
//   offset=0xF10C stable across entire LCU 3 RUN.
//  reset asserted mid-LCU 2 -> outputs 0 next cycle, no done; new start restarts at LCU 0.
//  start with cfg_lcu_size=3 -> stays IDLE, no img_rd/prm_rd, done never pulses.

Source files
------------

// File: rtl/ipf_pkg.sv
// Shared constants and LCU geometry helpers for the IPF frame scheduler.
package ipf_pkg;

    localparam logic [1:0] LCU_SZ_ILLEGAL = 2'd3;

    // Param word layout: {type, band_pos, wo_class, offset}
    localparam int PRM_TYPE_HI = 23;
    localparam int PRM_TYPE_LO = 22;
    localparam int PRM_BAND_HI = 21;
    localparam int PRM_BAND_LO = 17;
    localparam int PRM_WO_BIT  = 16;
    localparam int PRM_OFF_HI  = 15;
    localparam int PRM_OFF_LO  = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PARAM,
        S_PLAT,
        S_RUN,
        S_NEXT,
        S_DONE
    } sched_state_t;

    function automatic logic [2:0] lcu_shift(input logic [1:0] sz);
        return 3'd4 + {1'b0, sz};
    endfunction

    function automatic logic [6:0] lcu_len(input logic [1:0] sz);
        return 7'd16 << sz;
    endfunction

    function automatic logic [12:0] lcu_pix(input logic [1:0] sz);
        return 13'd256 << {sz, 1'b0};
    endfunction

    // Highest LCU grid index along one axis (N-1).
    function automatic logic [2:0] lcu_last(input logic [1:0] sz);
        return 3'd7 >> sz;
    endfunction

endpackage

// File: rtl/ipf_pix_fifo.sv
// Two-entry pixel prefetch FIFO between the image ROM and the filter input.
module ipf_pix_fifo #(
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic [1:0]        o_count
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              w_push;
    logic              w_pop;

    assign w_push  = i_push && (r_count != 2'd2);
    assign w_pop   = i_pop && (r_count != 2'd0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ipf_lcu_scheduler.sv
// Frame sequencer: walks LCUs in raster order, loads per-LCU filter params,
// streams LCU pixels through a prefetch FIFO and closes each LCU on output count.
module ipf_lcu_scheduler
    import ipf_pkg::*;
#(
    parameter int IMG_W = 128,
    parameter int AW    = 14,
    parameter int PW    = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    cfg_lcu_size,
    output logic [AW-1:0] img_addr,
    output logic          img_rd,
    input  logic [7:0]    img_data,
    output logic [5:0]    prm_addr,
    output logic          prm_rd,
    input  logic [PW-1:0] prm_data,
    input  logic          ipf_busy,
    input  logic          ipf_out_en,
    output logic          in_en,
    output logic [7:0]    din,
    output logic [1:0]    ipf_type,
    output logic [4:0]    ipf_band_pos,
    output logic          ipf_wo_class,
    output logic [15:0]   ipf_offset,
    output logic [2:0]    lcu_x,
    output logic [2:0]    lcu_y,
    output logic [1:0]    lcu_size,
    output logic          done
);

    localparam int CW = $clog2(IMG_W);

    sched_state_t  r_state;
    sched_state_t  w_state_nxt;
    logic [1:0]    r_size;
    logic [2:0]    r_lcu_x;
    logic [2:0]    r_lcu_y;
    logic [12:0]   r_feed_cnt;
    logic [12:0]   r_out_cnt;
    logic          r_inflight;
    logic [1:0]    r_ipf_type;
    logic [4:0]    r_ipf_band_pos;
    logic          r_ipf_wo_class;
    logic [15:0]   r_ipf_offset;

    logic [2:0]    w_shift;
    logic [6:0]    w_len;
    logic [12:0]   w_pix_total;
    logic [2:0]    w_last_idx;
    logic          w_last_lcu;
    logic          w_lcu_done;
    logic [CW-1:0] w_row_off;
    logic [CW-1:0] w_col_off;
    logic [CW-1:0] w_row;
    logic [CW-1:0] w_col;
    logic          w_run;
    logic          w_rd;
    logic          w_pop;
    logic [1:0]    w_fifo_cnt;
    logic [7:0]    w_fifo_head;

    assign w_shift     = lcu_shift(r_size);
    assign w_len       = lcu_len(r_size);
    assign w_pix_total = lcu_pix(r_size);
    assign w_last_idx  = lcu_last(r_size);
    assign w_last_lcu  = (r_lcu_x == w_last_idx) && (r_lcu_y == w_last_idx);
    assign w_lcu_done  = (r_out_cnt == w_pix_total);
    assign w_run       = (r_state == S_RUN);

    // Pixel index within the LCU splits into row/column by the power-of-two LCU width.
    assign w_row_off = CW'(r_feed_cnt >> w_shift);
    assign w_col_off = CW'(r_feed_cnt) & CW'(w_len - 7'd1);
    assign w_row     = (CW'(r_lcu_y) << w_shift) + w_row_off;
    assign w_col     = (CW'(r_lcu_x) << w_shift) + w_col_off;

    // A read is only issued when the FIFO is guaranteed room for its data.
    assign w_rd  = w_run && ((w_fifo_cnt + {1'b0, r_inflight}) < 2'd2) && (r_feed_cnt < w_pix_total);
    assign w_pop = in_en && !ipf_busy;

    assign img_rd       = w_rd;
    assign img_addr     = w_rd ? AW'({w_row, w_col}) : '0;
    assign prm_rd       = (r_state == S_PARAM);
    assign prm_addr     = prm_rd ? {r_lcu_y, r_lcu_x} : 6'd0;
    assign in_en        = w_run && (w_fifo_cnt != 2'd0);
    assign din          = w_fifo_head;
    assign done         = (r_state == S_DONE);
    assign ipf_type     = r_ipf_type;
    assign ipf_band_pos = r_ipf_band_pos;
    assign ipf_wo_class = r_ipf_wo_class;
    assign ipf_offset   = r_ipf_offset;
    assign lcu_x        = r_lcu_x;
    assign lcu_y        = r_lcu_y;
    assign lcu_size     = r_size;

    ipf_pix_fifo #(
        .DATA_W (8)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_push  (r_inflight),
        .i_data  (img_data),
        .i_pop   (w_pop),
        .o_head  (w_fifo_head),
        .o_count (w_fifo_cnt)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start && (cfg_lcu_size != LCU_SZ_ILLEGAL)) w_state_nxt = S_PARAM;
            S_PARAM: w_state_nxt = S_PLAT;
            S_PLAT:  w_state_nxt = S_RUN;
            S_RUN:   if (w_lcu_done) w_state_nxt = S_NEXT;
            S_NEXT:  w_state_nxt = w_last_lcu ? S_DONE : S_PARAM;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_size         <= 2'd0;
            r_lcu_x        <= 3'd0;
            r_lcu_y        <= 3'd0;
            r_feed_cnt     <= 13'd0;
            r_out_cnt      <= 13'd0;
            r_inflight     <= 1'b0;
            r_ipf_type     <= 2'd0;
            r_ipf_band_pos <= 5'd0;
            r_ipf_wo_class <= 1'b0;
            r_ipf_offset   <= 16'd0;
        end else begin
            r_inflight <= w_rd;
            case (r_state)
                S_IDLE: begin
                    if (w_state_nxt == S_PARAM) begin
                        r_size     <= cfg_lcu_size;
                        r_lcu_x    <= 3'd0;
                        r_lcu_y    <= 3'd0;
                        r_feed_cnt <= 13'd0;
                        r_out_cnt  <= 13'd0;
                    end
                end
                S_PLAT: begin
                    r_ipf_type     <= prm_data[PRM_TYPE_HI:PRM_TYPE_LO];
                    r_ipf_band_pos <= prm_data[PRM_BAND_HI:PRM_BAND_LO];
                    r_ipf_wo_class <= prm_data[PRM_WO_BIT];
                    r_ipf_offset   <= prm_data[PRM_OFF_HI:PRM_OFF_LO];
                end
                S_RUN: begin
                    if (w_rd) r_feed_cnt <= r_feed_cnt + 13'd1;
                    if (ipf_out_en) r_out_cnt <= r_out_cnt + 13'd1;
                end
                S_NEXT: begin
                    r_feed_cnt <= 13'd0;
                    r_out_cnt  <= 13'd0;
                    if (!w_last_lcu) begin
                        if (r_lcu_x == w_last_idx) begin
                            r_lcu_x <= 3'd0;
                            r_lcu_y <= r_lcu_y + 3'd1;
                        end else begin
                            r_lcu_x <= r_lcu_x + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
